// File: rtl/sprite_palette_fx_ctrl.sv
// Sprite palette pipeline: registers the index into the palette, then registers the
// keyed and effect-modified colour. The damage-flash / respawn-blink FSM advances on frame ticks.
module sprite_palette_fx_ctrl #(
    parameter logic [11:0] KEY_COLOR    = 12'h0E1,
    parameter int          FLASH_FRAMES = 8,
    parameter int          BLINK_FRAMES = 120,
    parameter int          BLINK_PERIOD = 4,
    parameter logic [3:0]  FLASH_BOOST  = 4'h6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       respawn,
    input  logic       pix_valid,
    input  logic [2:0] pix_index,
    output logic [2:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic       out_valid,
    output logic [3:0] out_red,
    output logic [3:0] out_green,
    output logic [3:0] out_blue,
    output logic       out_opaque,
    output logic [1:0] fx_state
);
    localparam int MAXF = (FLASH_FRAMES > BLINK_FRAMES) ? FLASH_FRAMES : BLINK_FRAMES;
    localparam int CW   = $clog2(MAXF + 1);
    localparam int PW   = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

    typedef enum logic [1:0] {ST_NORMAL = 2'd0, ST_FLASH = 2'd1, ST_BLINK = 2'd2} fx_e;

    fx_e           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          vis_q, vis_d;

    logic [2:0]    pal_index_q;
    logic          v0_q;
    logic          out_valid_q, out_opaque_q;
    logic [11:0]   rgb_q, rgb_d;
    logic          key;

    // Saturating per-channel brighten, widened to 5 bits so the carry is visible.
    function automatic logic [3:0] boost(input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, c} + {1'b0, FLASH_BOOST};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    always_comb begin
        key   = ({pal_red, pal_green, pal_blue} == KEY_COLOR);
        rgb_d = {pal_red, pal_green, pal_blue};
        if (state_q == ST_FLASH)
            rgb_d = {boost(pal_red), boost(pal_green), boost(pal_blue)};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pal_index_q  <= 3'd0;
            v0_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_opaque_q <= 1'b0;
            rgb_q        <= 12'h000;
        end else begin
            pal_index_q  <= pix_index;
            v0_q         <= pix_valid;
            out_valid_q  <= v0_q;
            out_opaque_q <= v0_q & ~key & ((state_q != ST_BLINK) | vis_q);
            if (v0_q)
                rgb_q <= rgb_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            phase_q <= '0;
            vis_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            vis_q   <= vis_d;
        end
    end

    // Priority respawn > hit > frame_tick; an entering event swallows a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        vis_d   = vis_q;
        if (respawn) begin
            state_d = ST_BLINK;
            cnt_d   = CW'(BLINK_FRAMES);
            phase_d = '0;
            vis_d   = 1'b1;
        end else if (hit && state_q != ST_BLINK) begin
            state_d = ST_FLASH;
            cnt_d   = CW'(FLASH_FRAMES);
        end else if (frame_tick) begin
            case (state_q)
                ST_FLASH: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = ST_NORMAL;
                end
                ST_BLINK: begin
                    cnt_d = cnt_q - CW'(1);
                    if (phase_q == PW'(BLINK_PERIOD - 1)) begin
                        phase_d = '0;
                        vis_d   = ~vis_q;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_NORMAL;
                        phase_d = '0;
                        vis_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pal_index  = pal_index_q;
    assign out_valid  = out_valid_q;
    assign out_opaque = out_opaque_q;
    assign {out_red, out_green, out_blue} = rgb_q;
    assign fx_state   = state_q;
endmodule

// File: tb/tb_sprite_palette_fx_ctrl.sv
// Scoreboard bench for sprite_palette_fx_ctrl: a fixed palette table answers pal_index,
// expected pixels are queued at drive time and popped when out_valid appears.
module tb_sprite_palette_fx_ctrl;
    logic       Clk, Reset, frame_tick, hit, respawn, pix_valid;
    logic [2:0] pix_index, pal_index;
    logic [3:0] pal_red, pal_green, pal_blue;
    logic       out_valid, out_opaque;
    logic [3:0] out_red, out_green, out_blue;
    logic [1:0] fx_state;

    int vectors = 0;
    int miscompares = 0;
    logic sb_on = 1'b0;
    logic [12:0] sbq[$];

    logic [11:0] pal [8] = '{12'h123, 12'h000, 12'h0E1, 12'hB86,
                             12'hD30, 12'hFFF, 12'h0E0, 12'h5A5};

    assign {pal_red, pal_green, pal_blue} = pal[pal_index];

    sprite_palette_fx_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .hit(hit), .respawn(respawn),
        .pix_valid(pix_valid), .pix_index(pix_index), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .out_valid(out_valid), .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_opaque(out_opaque), .fx_state(fx_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] sat6(input logic [3:0] c);
        int s;
        s = int'(c) + 6;
        return (s > 15) ? 4'hF : 4'(s);
    endfunction

    // {rgb, opaque} the pixel should produce; flash boosts but keys on the raw colour.
    function automatic logic [12:0] exp_px(input logic [2:0] idx, input logic fl, input logic vis);
        logic [11:0] c;
        logic        op;
        c  = pal[idx];
        op = (c != 12'h0E1) && vis;
        if (fl) c = {sat6(c[11:8]), sat6(c[7:4]), sat6(c[3:0])};
        return {c, op};
    endfunction

    always @(negedge Clk) begin
        if (sb_on) begin
            if (out_valid === 1'b1) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: out_valid=1 got %h, want no pixel",
                             {out_red, out_green, out_blue, out_opaque});
                end else begin
                    logic [12:0] want;
                    want = sbq.pop_front();
                    if ({out_red, out_green, out_blue, out_opaque} !== want) begin
                        miscompares++;
                        $display("FAIL sb_pixel: got rgb=%h op=%b, want rgb=%h op=%b",
                                 {out_red, out_green, out_blue}, out_opaque, want[12:1], want[0]);
                    end
                end
            end else begin
                vectors++;
                if (out_opaque !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_opaque: got %b want 0", out_opaque);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] idx, input logic ft,
                         input logic h, input logic r, input logic [12:0] exp);
        pix_valid = v; pix_index = idx; frame_tick = ft; hit = h; respawn = r;
        if (v && sb_on) sbq.push_back(exp);
        @(posedge Clk); #1;
        pix_valid = 1'b0; frame_tick = 1'b0; hit = 1'b0; respawn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 13'h0);
    endtask

    task automatic test_reset;
        Reset = 1'b1; pix_valid = 0; pix_index = 3'd5; frame_tick = 0; hit = 0; respawn = 0;
        repeat (3) @(posedge Clk);
        #1;
        vectors++; if (pal_index !== 3'd0) begin miscompares++; $display("FAIL rst_pal_index: got %0d want 0", pal_index); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_opaque !== 1'b0) begin miscompares++; $display("FAIL rst_out_opaque: got %b want 0", out_opaque); end
        vectors++; if ({out_red, out_green, out_blue} !== 12'h000) begin miscompares++; $display("FAIL rst_rgb: got %h want 000", {out_red, out_green, out_blue}); end
        vectors++; if (fx_state !== 2'd0) begin miscompares++; $display("FAIL rst_fx_state: got %0d want 0", fx_state); end
        Reset = 1'b0;
        @(posedge Clk); #1;
        sb_on = 1'b1;
    endtask

    task automatic test_normal;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_px(3'd1, 1'b0, 1'b1));
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: got out_valid=%b want 0", out_valid); end
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, exp_px(3'd3, 1'b0, 1'b1));
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency_n2: got out_valid=%b want 1", out_valid); end
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, exp_px(3'd2, 1'b0, 1'b1));
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, exp_px(3'd5, 1'b0, 1'b1));
        idle(3);
        vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL normal_drain: got %0d pending want 0", sbq.size()); end
    endtask

    task automatic test_flash;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd1) begin miscompares++; $display("FAIL flash_enter: got %0d want 1", fx_state); end
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, exp_px(3'd3, 1'b1, 1'b1));
        drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, exp_px(3'd4, 1'b1, 1'b1));
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, exp_px(3'd2, 1'b1, 1'b1));
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, exp_px(3'd5, 1'b1, 1'b1));
        idle(2);
        for (int t = 0; t < 7; t++) drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd1) begin miscompares++; $display("FAIL flash_7ticks: got %0d want 1", fx_state); end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd0) begin miscompares++; $display("FAIL flash_exit: got %0d want 0", fx_state); end
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, exp_px(3'd3, 1'b0, 1'b1));
        idle(3);
        vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL flash_drain: got %0d pending want 0", sbq.size()); end
    endtask

    task automatic test_retrigger;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 13'h0);
        for (int t = 0; t < 5; t++) drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 13'h0);
        for (int t = 0; t < 7; t++) drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd1) begin miscompares++; $display("FAIL retrig_7ticks: got %0d want 1", fx_state); end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd0) begin miscompares++; $display("FAIL retrig_exit: got %0d want 0", fx_state); end
        // hit with a coincident tick must load the full count
        drive(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 13'h0);
        for (int t = 0; t < 7; t++) drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd1) begin miscompares++; $display("FAIL hit_tick_7: got %0d want 1", fx_state); end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        vectors++; if (fx_state !== 2'd0) begin miscompares++; $display("FAIL hit_tick_exit: got %0d want 0", fx_state); end
    endtask

    task automatic test_blink;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 13'h0);
        for (int f = 0; f <= 120; f++) begin
            logic vis;
            logic [1:0] want_st;
            vis     = (f == 120) ? 1'b1 : (((f / 4) % 2) == 0);
            want_st = (f == 120) ? 2'd0 : 2'd2;
            vectors++;
            if (fx_state !== want_st) begin
                miscompares++;
                $display("FAIL blink_state f=%0d: got %0d want %0d", f, fx_state, want_st);
            end
            for (int p = 0; p < 3; p++) drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, exp_px(3'd3, 1'b0, vis));
            idle(2);
            if (f == 50) begin
                drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 13'h0);
                vectors++; if (fx_state !== 2'd2) begin miscompares++; $display("FAIL blink_hit_ignored: got %0d want 2", fx_state); end
            end
            if (f < 120) drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 13'h0);
        end
        idle(1);
        vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL blink_drain: got %0d pending want 0", sbq.size()); end
    endtask

    task automatic test_hit_respawn;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 13'h0);
        vectors++; if (fx_state !== 2'd2) begin miscompares++; $display("FAIL hit_respawn: got %0d want 2", fx_state); end
    endtask

    task automatic test_reset_mid;
        sb_on = 1'b0; sbq.delete();
        Reset = 1'b1; #2; Reset = 1'b0;
        @(posedge Clk); #1;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 13'h0);
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 13'h0);
        pix_valid = 1'b1; pix_index = 3'd4;
        @(posedge Clk); #1;
        vectors++; if (fx_state !== 2'd1) begin miscompares++; $display("FAIL mid_pre_state: got %0d want 1", fx_state); end
        #2 Reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        vectors++; if (fx_state !== 2'd0) begin miscompares++; $display("FAIL mid_fx_state: got %0d want 0", fx_state); end
        vectors++; if (pal_index !== 3'd0) begin miscompares++; $display("FAIL mid_pal_index: got %0d want 0", pal_index); end
        @(posedge Clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_held_valid: got %b want 0", out_valid); end
        pix_valid = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;
        idle(1);
        sb_on = 1'b1;
        drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, exp_px(3'd4, 1'b0, 1'b1));
        idle(3);
        vectors++; if (sbq.size() != 0) begin miscompares++; $display("FAIL post_reset_drain: got %0d pending want 0", sbq.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_flash();
        test_retrigger();
        test_blink();
        test_hit_respawn();
        test_reset_mid();
        sb_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
